// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/shift/rotate, iterative
// shift-add multiply and restoring divide, with an IDLE/CALC/DONE handshake.
module seq_alu #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             overflow,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1110;
  localparam logic [3:0] OP_AND = 4'b1101;
  localparam logic [3:0] OP_OR  = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b1010;
  localparam logic [3:0] OP_SHR = 4'b1011;
  localparam logic [3:0] OP_ROL = 4'b1000;
  localparam logic [3:0] OP_ROR = 4'b1001;

  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] SMAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_op_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_ovf;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_overflow;
  logic               r_div_zero;

  logic [WIDTH-1:0]   w_bx;
  logic [WIDTH-1:0]   w_sum;
  logic               w_add_ovf;
  logic [WIDTH-1:0]   w_amt;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_is_calc;
  logic [WIDTH-1:0]   w_sc_res;
  logic [WIDTH-1:0]   w_sc_rem;
  logic               w_sc_ovf;
  logic               w_sc_dz;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH:0]     w_ddiff;
  logic [WIDTH-1:0]   w_hi_nx;
  logic [WIDTH-1:0]   w_lo_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_md_res;
  logic [WIDTH-1:0]   w_md_rem;
  logic               w_md_ovf;

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign remainder = r_remainder;
  assign overflow  = r_overflow;
  assign div_zero  = r_div_zero;

  // SUB reuses the adder with B inverted plus a carry-in.
  assign w_bx      = (ctrl == OP_SUB) ? ~op_b : op_b;
  assign w_sum     = op_a + w_bx + {{(WIDTH-1){1'b0}}, (ctrl == OP_SUB)};
  assign w_add_ovf = (op_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
  assign w_amt     = op_b % W_VAL;
  assign w_abs_a   = op_a[WIDTH-1] ? -op_a : op_a;
  assign w_abs_b   = op_b[WIDTH-1] ? -op_b : op_b;
  assign w_is_calc = (ctrl == OP_MUL) || ((ctrl == OP_DIV) && (op_b != '0));

  always_comb begin
    w_sc_res = '0;
    w_sc_rem = '0;
    w_sc_ovf = 1'b0;
    w_sc_dz  = 1'b0;
    case (ctrl)
      OP_ADD, OP_SUB: begin
        if (w_add_ovf) begin
          w_sc_ovf = 1'b1;
          w_sc_res = SATURATE ? (op_a[WIDTH-1] ? SMIN : SMAX) : '0;
        end else begin
          w_sc_res = w_sum;
        end
      end
      OP_AND: w_sc_res = op_a & op_b;
      OP_OR:  w_sc_res = op_a | op_b;
      OP_SHL: w_sc_res = (op_b >= W_VAL) ? '0 : (op_a << op_b);
      OP_SHR: w_sc_res = (op_b >= W_VAL) ? {WIDTH{op_a[WIDTH-1]}}
                                         : $unsigned($signed(op_a) >>> op_b);
      OP_ROL: w_sc_res = (op_a << w_amt) | (op_a >> (W_VAL - w_amt));
      OP_ROR: w_sc_res = (op_a >> w_amt) | (op_a << (W_VAL - w_amt));
      OP_DIV: begin
        w_sc_dz  = 1'b1;
        w_sc_rem = op_a;
      end
      default: ;
    endcase
  end

  // One iteration per CALC cycle; both datapaths work on magnitudes in r_hi:r_lo.
  assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag} : '0);
  assign w_dshift = {r_hi, r_lo[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_mag};
  assign w_hi_nx  = r_op_div ? (w_ddiff[WIDTH] ? w_dshift[WIDTH-1:0] : w_ddiff[WIDTH-1:0])
                             : w_msum[WIDTH:1];
  assign w_lo_nx  = r_op_div ? {r_lo[WIDTH-2:0], ~w_ddiff[WIDTH]}
                             : {w_msum[0], r_lo[WIDTH-1:1]};
  assign w_prod   = {w_hi_nx, w_lo_nx};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

  always_comb begin
    w_md_res = w_prod_s[WIDTH-1:0];
    w_md_rem = w_prod_s[2*WIDTH-1:WIDTH];
    w_md_ovf = 1'b0;
    if (r_op_div) begin
      if (r_div_ovf) begin
        w_md_res = SATURATE ? SMAX : '0;
        w_md_rem = '0;
        w_md_ovf = 1'b1;
      end else begin
        w_md_res = r_neg_q ? -w_lo_nx : w_lo_nx;
        w_md_rem = r_neg_r ? -w_hi_nx : w_hi_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div_ovf   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_mag       <= '0;
      r_result    <= '0;
      r_remainder <= '0;
      r_overflow  <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_calc) begin
              r_state   <= S_CALC;
              r_cnt     <= '0;
              r_op_div  <= (ctrl == OP_DIV);
              r_neg_q   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
              r_neg_r   <= op_a[WIDTH-1];
              r_div_ovf <= (op_a == SMIN) && (op_b == '1);
              r_hi      <= '0;
              r_lo      <= (ctrl == OP_DIV) ? w_abs_a : w_abs_b;
              r_mag     <= (ctrl == OP_DIV) ? w_abs_b : w_abs_a;
            end else begin
              r_state     <= S_DONE;
              r_result    <= w_sc_res;
              r_remainder <= w_sc_rem;
              r_overflow  <= w_sc_ovf;
              r_div_zero  <= w_sc_dz;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH-1)) begin
            r_state     <= S_DONE;
            r_result    <= w_md_res;
            r_remainder <= w_md_rem;
            r_overflow  <= w_md_ovf;
            r_div_zero  <= 1'b0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: two instances (SATURATE=0 and 1) share stimulus,
// expected responses are queued at issue and checked by per-instance monitors on done.
module tb_seq_alu;

   typedef struct {
      logic [15:0] res;
      logic [15:0] rem;
      logic        ovf;
      logic        dz;
      int          cyc;
   } exp_t;

   localparam logic [3:0] OP_ADD = 4'b1111;
   localparam logic [3:0] OP_SUB = 4'b1110;
   localparam logic [3:0] OP_AND = 4'b1101;
   localparam logic [3:0] OP_OR  = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b0001;
   localparam logic [3:0] OP_DIV = 4'b0010;
   localparam logic [3:0] OP_SHL = 4'b1010;
   localparam logic [3:0] OP_SHR = 4'b1011;
   localparam logic [3:0] OP_ROL = 4'b1000;
   localparam logic [3:0] OP_ROR = 4'b1001;
   localparam logic [3:0] OP_NOP = 4'b0000;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  ctrl = 4'd0;
   logic [15:0] opA = 16'd0;
   logic [15:0] opB = 16'd0;
   logic        busy0, done0, ovf0, dz0;
   logic        busy1, done1, ovf1, dz1;
   logic [15:0] res0, rem0, res1, rem1;

   int   cyc = 0;
   int   nChecks = 0;
   int   nFails = 0;
   exp_t q0[$];
   exp_t q1[$];

   seq_alu #(.WIDTH(16), .SATURATE(1'b0)) dut0 (
      .clk(clk), .rst_n(rstN), .start(start), .ctrl(ctrl), .op_a(opA), .op_b(opB),
      .busy(busy0), .done(done0), .result(res0), .remainder(rem0),
      .overflow(ovf0), .div_zero(dz0)
   );

   seq_alu #(.WIDTH(16), .SATURATE(1'b1)) dut1 (
      .clk(clk), .rst_n(rstN), .start(start), .ctrl(ctrl), .op_a(opA), .op_b(opB),
      .busy(busy1), .done(done1), .result(res1), .remainder(rem1),
      .overflow(ovf1), .div_zero(dz1)
   );

   // Free-running clock and a cycle counter used to check done latency.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Shared comparison helper; every check in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor for the non-saturating instance: pop and compare on every done pulse.
   always @(negedge clk) begin : monitor0
      exp_t e;
      if (done0) begin
         if (q0.size() == 0) begin
            checkOutput("dut0 unexpected done", 32'd1, 32'd0);
         end else begin
            e = q0.pop_front();
            checkOutput("dut0 result", {16'd0, res0}, {16'd0, e.res});
            checkOutput("dut0 remainder", {16'd0, rem0}, {16'd0, e.rem});
            checkOutput("dut0 overflow", {31'd0, ovf0}, {31'd0, e.ovf});
            checkOutput("dut0 div_zero", {31'd0, dz0}, {31'd0, e.dz});
            checkOutput("dut0 done cycle", cyc, e.cyc);
         end
      end
   end

   // Monitor for the saturating instance.
   always @(negedge clk) begin : monitor1
      exp_t e;
      if (done1) begin
         if (q1.size() == 0) begin
            checkOutput("dut1 unexpected done", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            checkOutput("dut1 result", {16'd0, res1}, {16'd0, e.res});
            checkOutput("dut1 remainder", {16'd0, rem1}, {16'd0, e.rem});
            checkOutput("dut1 overflow", {31'd0, ovf1}, {31'd0, e.ovf});
            checkOutput("dut1 div_zero", {31'd0, dz1}, {31'd0, e.dz});
            checkOutput("dut1 done cycle", cyc, e.cyc);
         end
      end
   end

   // Issue one operation, queue its expected response, scramble operands and
   // optionally poke start mid-operation; busy is checked every cycle until idle.
   task automatic applyStimulus(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] expRes0, input logic [15:0] expRes1,
                                input logic [15:0] expRem, input logic expOvf, input logic expDz,
                                input int lat, input bit poke);
      exp_t e0;
      exp_t e1;
      ctrl  = c;
      opA   = a;
      opB   = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e0.res = expRes0; e0.rem = expRem; e0.ovf = expOvf; e0.dz = expDz; e0.cyc = cyc + lat - 1;
      e1 = e0;
      e1.res = expRes1;
      q0.push_back(e0);
      q1.push_back(e1);
      opA = 16'($urandom);
      opB = 16'($urandom);
      for (int k = 0; k < lat; k++) begin
         checkOutput("busy during op", {31'd0, busy0}, 32'd1);
         if (poke && k == 3) begin
            ctrl  = OP_ADD;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      checkOutput("busy after op", {31'd0, busy0}, 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset busy", {31'd0, busy0}, 32'd0);
      checkOutput("reset done", {31'd0, done0}, 32'd0);
      checkOutput("reset result", {16'd0, res0}, 32'd0);
      checkOutput("reset remainder", {16'd0, rem0}, 32'd0);
      checkOutput("reset flags", {30'd0, ovf0, dz0}, 32'd0);
      rstN = 1'b1;

      //              op      a         b         res0      res1      rem       ov    dz   lat poke
      applyStimulus(OP_ADD, 16'h7FFF, 16'h0001, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1,  1'b0);
      applyStimulus(OP_ADD, 16'h1234, 16'h1111, 16'h2345, 16'h2345, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_SUB, 16'h8000, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1,  1'b0);
      applyStimulus(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h3030, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_OR,  16'hF0F0, 16'h0F01, 16'hFFF1, 16'hFFF1, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h3400, 16'h0012, 1'b0, 1'b0, 17, 1'b0);
      applyStimulus(OP_MUL, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFF1, 16'hFFFF, 1'b0, 1'b0, 17, 1'b0);
      applyStimulus(OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17, 1'b0);
      applyStimulus(OP_DIV, 16'h0064, 16'h0007, 16'h000E, 16'h000E, 16'h0002, 1'b0, 1'b0, 17, 1'b0);
      applyStimulus(OP_DIV, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b1, 1,  1'b0);
      applyStimulus(OP_DIV, 16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 17, 1'b0);
      applyStimulus(OP_ROL, 16'h8001, 16'd17,   16'h0003, 16'h0003, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_ROR, 16'h0001, 16'd4,    16'h1000, 16'h1000, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_SHR, 16'h8000, 16'd20,   16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_SHR, 16'h8000, 16'd4,    16'hF800, 16'hF800, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_SHL, 16'h0001, 16'd16,   16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_SHL, 16'h0003, 16'd4,    16'h0030, 16'h0030, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_NOP, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
      applyStimulus(OP_MUL, 16'h0003, 16'h0004, 16'h000C, 16'h000C, 16'h0000, 1'b0, 1'b0, 17, 1'b1);

      // Abort a multiply mid-CALC; outputs must clear without waiting for a clock.
      ctrl  = OP_MUL;
      opA   = 16'h1234;
      opB   = 16'h0100;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("busy mid-CALC", {31'd0, busy0}, 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("async reset busy", {31'd0, busy0}, 32'd0);
      checkOutput("async reset done", {31'd0, done0}, 32'd0);
      checkOutput("async reset result", {16'd0, res0}, 32'd0);
      checkOutput("async reset result sat", {16'd0, res1}, 32'd0);
      checkOutput("async reset remainder", {16'd0, rem0}, 32'd0);
      checkOutput("async reset flags", {30'd0, ovf0, dz0}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rstN = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      checkOutput("idle after aborted op", {31'd0, busy0}, 32'd0);

      applyStimulus(OP_ADD, 16'h0001, 16'h0002, 16'h0003, 16'h0003, 16'h0000, 1'b0, 1'b0, 1, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("dut0 scoreboard drained", q0.size(), 32'd0);
      checkOutput("dut1 scoreboard drained", q1.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
